// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: load/store codes, FSM states and
// control-field bit positions. MEM_MISALIGN_DET_EN enables misalignment detection in mem_access_unit.
package mem_pkg;

    localparam int MEM_RD_EN_BIT = 3;
    localparam int MEM_WR_EN_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_SB = 2'b00;
    localparam logic [1:0] SZ_SH = 2'b01;
    localparam logic [1:0] SZ_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Load and store sizes share the byte/half/word encoding in their low two bits.
    function automatic logic [1:0] access_size(input logic       is_load,
                                               input logic [2:0] ld_funct3,
                                               input logic [1:0] st_size);
        return is_load ? ld_funct3[1:0] : st_size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic is_word;
        is_word = (size != SZ_SB) && (size != SZ_SH);
        return ((size == SZ_SH) && a[0]) || (is_word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: byte enables, store-data replication, and load
// extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  st_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [1:0]  size;
    logic [15:0] lane;

    assign size = access_size(is_load, ld_funct3, st_size);

    // Stores replicate into every lane; the enables pick which lanes land.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SZ_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_SH: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = 16'(rdata >> {addr_lo, 3'b000});

    always_comb begin
        case (ld_funct3)
            F3_LB:   load_ext = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_ext = {{16{lane[15]}}, lane};
            F3_LBU:  load_ext = {24'd0, lane[7:0]};
            F3_LHU:  load_ext = {16'd0, lane};
            F3_LW:   load_ext = rdata;
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: req/ack FSM with pipeline stall (busywait).
// Optional MEM_MISALIGN_DET_EN adds misalign_err and suppresses misaligned accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_read,
    input  logic [2:0]            mem_write,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    output logic                  busywait,
    output logic [31:0]           load_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
`ifdef MEM_MISALIGN_DET_EN
    ,
    output logic                  misalign_err
`endif
);

    state_t                state;
    logic [31:0]           rdata_q;
    logic                  is_load;
    logic                  access;
    logic                  start;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           load_ext;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign is_load = mem_read[MEM_RD_EN_BIT];
    assign access  = is_load | mem_write[MEM_WR_EN_BIT];

    mem_align u_align (
        .is_load    (is_load),
        .ld_funct3  (mem_read[2:0]),
        .st_size    (mem_write[1:0]),
        .addr_lo    (alu_result[1:0]),
        .store_data (store_data),
        .rdata      (rdata_q),
        .be         (be),
        .wdata      (wdata),
        .load_ext   (load_ext)
    );

    generate
        if (ADDR_WIDTH <= 32) begin : g_addr_narrow
            assign word_addr = {alu_result[ADDR_WIDTH-1:2], 2'b00};
        end else begin : g_addr_wide
            assign word_addr = {{(ADDR_WIDTH-32){1'b0}}, alu_result[31:2], 2'b00};
        end
    endgenerate

`ifdef MEM_MISALIGN_DET_EN
    logic misaligned;
    assign misaligned   = access &
                          is_misaligned(access_size(is_load, mem_read[2:0], mem_write[1:0]),
                                        alu_result[1:0]);
    assign start        = access & ~misaligned;
    assign misalign_err = (state == IDLE) & misaligned;
`else
    assign start = access;
`endif

    // DONE always falls back to IDLE so the still-held inputs cannot re-issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= ~is_load;
                        mem_addr  <= word_addr;
                        mem_be    <= be;
                        mem_wdata <= wdata;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = start;
            WAIT:    busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    assign load_data = ((state == DONE) && is_load) ? load_ext : 32'd0;

endmodule
